// File: rtl/adder_seq_pkg.sv
// Shared definitions for the board adder sequencer: state codes and default width.
package adder_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_A    = 2'b00;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_ADD  = 2'b10;
    localparam logic [1:0] S_SHOW = 2'b11;

    typedef enum logic [1:0] {
        ST_A    = S_A,
        ST_B    = S_B,
        ST_ADD  = S_ADD,
        ST_SHOW = S_SHOW
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous key level, with an optional
// registered single-cycle pulse on each rising edge of the synchronized level.
module sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic Clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [STAGES-1:0] syncChain;

    // Shift the asynchronous input through the synchronizer flops
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            syncChain <= '0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], din};
        end
    end

    assign level = syncChain[STAGES-1];

    generate
        if (EDGE_EN) begin : gEdge
            logic levelPrev;
            logic pulseReg;

            // Emit one clean pulse per low-to-high transition of the synchronized level
            always_ff @(posedge Clk or posedge reset) begin
                if (reset) begin
                    levelPrev <= 1'b0;
                    pulseReg  <= 1'b0;
                end else begin
                    levelPrev <= level;
                    pulseReg  <= level & ~levelPrev;
                end
            end

            assign pulse = pulseReg;
        end else begin : gNoEdge
            assign pulse = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/adder_sequencer.sv
// Sequencing controller for the board adder: collects A and B from the switch
// bank with one enter key, performs a registered add, shows the result and can
// chain further additions into a running accumulator.
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             enter,
    input  logic             clr,
    input  logic             mode,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             valid,
    output logic [1:0]       state
);

    logic entPulse;
    logic entLevel;
    logic clrLevel;
    logic unusedClrPulse;

    state_e           stateReg;
    state_e           stateNext;
    logic [WIDTH-1:0] opANext;
    logic [WIDTH-1:0] opBNext;
    logic [WIDTH-1:0] sumNext;
    logic             coutNext;
    logic             ovfNext;
    logic             chain;
    logic             chainNext;
    logic [WIDTH:0]   addFull;

    sync_edge #(
        .STAGES (SYNC_STAGES),
        .EDGE_EN(1'b1)
    ) uEnterSync (
        .Clk  (Clk),
        .reset(reset),
        .din  (enter),
        .level(entLevel),
        .pulse(entPulse)
    );

    sync_edge #(
        .STAGES (SYNC_STAGES),
        .EDGE_EN(1'b0)
    ) uClrSync (
        .Clk  (Clk),
        .reset(reset),
        .din  (clr),
        .level(clrLevel),
        .pulse(unusedClrPulse)
    );

    // Next-state and datapath decisions; clear wins over any enter pulse
    always_comb begin
        stateNext = stateReg;
        opANext   = op_a;
        opBNext   = op_b;
        sumNext   = sum;
        coutNext  = cout;
        ovfNext   = ovf;
        chainNext = chain;
        addFull   = {1'b0, op_a} + {1'b0, op_b};

        if (clrLevel) begin
            stateNext = ST_A;
            opANext   = '0;
            opBNext   = '0;
            sumNext   = '0;
            coutNext  = 1'b0;
            ovfNext   = 1'b0;
            chainNext = 1'b0;
        end else begin
            case (stateReg)
                ST_A: begin
                    if (entPulse) begin
                        opANext   = sw;
                        opBNext   = '0;
                        ovfNext   = 1'b0;
                        chainNext = 1'b0;
                        stateNext = ST_B;
                    end
                end
                ST_B: begin
                    if (entPulse) begin
                        opBNext   = sw;
                        stateNext = ST_ADD;
                    end
                end
                ST_ADD: begin
                    sumNext   = addFull[WIDTH-1:0];
                    coutNext  = addFull[WIDTH];
                    if (chain) begin
                        ovfNext = ovf | addFull[WIDTH];
                    end
                    stateNext = ST_SHOW;
                end
                ST_SHOW: begin
                    if (entPulse) begin
                        if (!mode) begin
                            opANext   = sw;
                            opBNext   = '0;
                            ovfNext   = 1'b0;
                            chainNext = 1'b0;
                            stateNext = ST_B;
                        end else begin
                            // The carry that produced the value being carried forward joins the sticky flag
                            opANext   = sum;
                            opBNext   = sw;
                            ovfNext   = ovf | cout;
                            chainNext = 1'b1;
                            stateNext = ST_ADD;
                        end
                    end
                end
                default: begin
                    stateNext = ST_A;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            stateReg <= ST_A;
            op_a     <= '0;
            op_b     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            chain    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            op_a     <= opANext;
            op_b     <= opBNext;
            sum      <= sumNext;
            cout     <= coutNext;
            ovf      <= ovfNext;
            chain    <= chainNext;
        end
    end

    assign valid = (stateReg == ST_SHOW);
    assign state = stateReg;

    // The synchronized enter level is only consumed through its edge pulse
    logic unusedEntLevel;
    assign unusedEntLevel = entLevel;

endmodule

// File: tb/tb_adder_sequencer.sv
// Directed, table-driven bench for adder_sequencer with hand-written multi-cycle sequences.
module tb_adder_sequencer;
    import adder_seq_pkg::*;

    logic       Clk;
    logic       reset;
    logic [7:0] sw;
    logic       enter;
    logic       clr;
    logic       mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       valid;
    logic [1:0] state;

    int vecCount;
    int missCount;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       expCout;
    } vec_t;

    vec_t vecs[6];

    adder_sequencer #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .sw   (sw),
        .enter(enter),
        .clr  (clr),
        .mode (mode),
        .op_a (op_a),
        .op_b (op_b),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf),
        .valid(valid),
        .state(state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic waitCycles(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Press the key with a switch value and mode, then release and let things settle
    task automatic applyStimulus(input logic [7:0] value, input logic modeVal, input int holdCycles);
        sw    = value;
        mode  = modeVal;
        enter = 1'b1;
        waitCycles(holdCycles);
        enter = 1'b0;
        waitCycles(6);
    endtask

    task automatic checkShow(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] s, input logic c, input logic o);
        checkOutput({tag, ".state"}, {30'd0, state}, {30'd0, S_SHOW});
        checkOutput({tag, ".valid"}, {31'd0, valid}, 32'd1);
        checkOutput({tag, ".op_a"}, {24'd0, op_a}, {24'd0, a});
        checkOutput({tag, ".op_b"}, {24'd0, op_b}, {24'd0, b});
        checkOutput({tag, ".sum"}, {24'd0, sum}, {24'd0, s});
        checkOutput({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
        checkOutput({tag, ".ovf"}, {31'd0, ovf}, {31'd0, o});
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, ".state"}, {30'd0, state}, {30'd0, S_A});
        checkOutput({tag, ".op_a"}, {24'd0, op_a}, 32'd0);
        checkOutput({tag, ".op_b"}, {24'd0, op_b}, 32'd0);
        checkOutput({tag, ".sum"}, {24'd0, sum}, 32'd0);
        checkOutput({tag, ".cout"}, {31'd0, cout}, 32'd0);
        checkOutput({tag, ".ovf"}, {31'd0, ovf}, 32'd0);
        checkOutput({tag, ".valid"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecCount  = 0;
        missCount = 0;
        reset = 1'b1;
        sw    = 8'h00;
        enter = 1'b0;
        clr   = 1'b0;
        mode  = 1'b0;

        vecs[0] = '{a: 8'h3C, b: 8'h05, expSum: 8'h41, expCout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, expSum: 8'h00, expCout: 1'b1};
        vecs[2] = '{a: 8'h7F, b: 8'h7F, expSum: 8'hFE, expCout: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h80, expSum: 8'h00, expCout: 1'b1};
        vecs[4] = '{a: 8'hA5, b: 8'h5A, expSum: 8'hFF, expCout: 1'b0};
        vecs[5] = '{a: 8'hC8, b: 8'h64, expSum: 8'h2C, expCout: 1'b1};

        waitCycles(3);
        checkCleared("reset");
        reset = 1'b0;
        waitCycles(2);

        // Pairwise adds: first from S_A after reset, the rest restart from S_SHOW with mode 0
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, 1'b0, 6);
            checkOutput($sformatf("vec%0d.afterA.state", i), {30'd0, state}, {30'd0, S_B});
            checkOutput($sformatf("vec%0d.afterA.op_a", i), {24'd0, op_a}, {24'd0, vecs[i].a});
            checkOutput($sformatf("vec%0d.afterA.op_b", i), {24'd0, op_b}, 32'd0);
            sw    = vecs[i].b;
            enter = 1'b1;
            waitCycles(4);
            checkOutput($sformatf("vec%0d.addCycle.state", i), {30'd0, state}, {30'd0, S_ADD});
            checkOutput($sformatf("vec%0d.addCycle.valid", i), {31'd0, valid}, 32'd0);
            waitCycles(1);
            checkShow($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expSum, vecs[i].expCout, 1'b0);
            enter = 1'b0;
            waitCycles(6);
        end

        // Accumulate chain: 0x80+0x80 leaves a carry that becomes sticky once chaining starts
        applyStimulus(8'h80, 1'b0, 6);
        applyStimulus(8'h80, 1'b0, 6);
        checkShow("accPair", 8'h80, 8'h80, 8'h00, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b1, 6);
        checkShow("acc1", 8'h00, 8'h01, 8'h01, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 6);
        checkShow("acc2", 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1);
        applyStimulus(8'h10, 1'b0, 6);
        checkOutput("accExit.state", {30'd0, state}, {30'd0, S_B});
        checkOutput("accExit.ovf", {31'd0, ovf}, 32'd0);
        checkOutput("accExit.op_a", {24'd0, op_a}, 32'h10);

        // Mode high while in S_B is ignored; a carry-free chain keeps ovf low
        applyStimulus(8'h20, 1'b1, 6);
        checkShow("modeInB", 8'h10, 8'h20, 8'h30, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b1, 6);
        checkShow("accNoCarry", 8'h30, 8'h05, 8'h35, 1'b0, 1'b0);

        // Held key in S_A: one pulse only, and a later switch change is not reloaded
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        waitCycles(1);
        sw    = 8'h11;
        mode  = 1'b0;
        enter = 1'b1;
        waitCycles(8);
        sw = 8'h22;
        waitCycles(12);
        checkOutput("held.state", {30'd0, state}, {30'd0, S_B});
        checkOutput("held.op_a", {24'd0, op_a}, 32'h11);
        checkOutput("held.op_b", {24'd0, op_b}, 32'd0);
        enter = 1'b0;
        waitCycles(6);
        checkOutput("heldRelease.state", {30'd0, state}, {30'd0, S_B});

        // Clear and enter together while in S_B with non-zero data around
        applyStimulus(8'hF0, 1'b0, 6);
        checkShow("preClr", 8'h11, 8'hF0, 8'h01, 1'b1, 1'b0);
        applyStimulus(8'h44, 1'b0, 6);
        checkOutput("preClr.state", {30'd0, state}, {30'd0, S_B});
        sw    = 8'h55;
        clr   = 1'b1;
        enter = 1'b1;
        waitCycles(6);
        clr   = 1'b0;
        enter = 1'b0;
        waitCycles(6);
        checkCleared("clrEnter");
        applyStimulus(8'h0A, 1'b0, 6);
        applyStimulus(8'h0B, 1'b0, 6);
        checkShow("postClr", 8'h0A, 8'h0B, 8'h15, 1'b0, 1'b0);

        // Asynchronous reset between clock edges while showing a chained result
        applyStimulus(8'hFF, 1'b1, 6);
        checkShow("preReset", 8'h15, 8'hFF, 8'h14, 1'b1, 1'b1);
        @(negedge Clk);
        #2;
        reset = 1'b1;
        #1;
        checkCleared("asyncReset");
        @(negedge Clk);
        reset = 1'b0;
        waitCycles(2);
        applyStimulus(8'h12, 1'b0, 6);
        applyStimulus(8'h34, 1'b0, 6);
        checkShow("postReset", 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Sequencing controller for the 8-bit board adder datapath. It collects operand A and operand B from the single switch bank through one "enter" key, triggers the registered add, holds the result for the hex displays, and optionally chains additions into a running accumulator. It sits between the board inputs (SW/KEY) and the existing adder plus hex-decoder path, and replaces the free-running register-and-add wiring with an explicit state machine.

## Interface

- `WIDTH`, default 8: operand and sum width.
- `SYNC_STAGES`, default 2: synchronizer flops on `enter` and `clr` (minimum 2).

- `Clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high. Clears every register.
- `sw`: input, WIDTH bits. Operand value, sampled only on an enter pulse.
- `enter`: input, 1 bit. Level from the key, active-high and asynchronous to `Clk`. Synchronized and rising-edge detected internally.
- `clr`: input, 1 bit. Level, active-high and asynchronous. Synchronized internally. Acts as a synchronous clear to the start state.
- `mode`: input, 1 bit. 0 = pairwise add, 1 = accumulate. Sampled only with an enter pulse in S_SHOW.
- `op_a`: output, WIDTH bits. Latched operand A.
- `op_b`: output, WIDTH bits. Latched operand B.
- `sum`: output, WIDTH bits. Registered low bits of `op_a + op_b`.
- `cout`: output, 1 bit. Registered carry of the last add.
- `ovf`: output, 1 bit. Sticky carry over an accumulate chain.
- `valid`: output, 1 bit. High while in S_SHOW.
- `state`: output, 2 bits. Current state code, used to drive a status display.

## Operation

- `enter` and `clr` each pass through `SYNC_STAGES` flops. `enter` then goes to a rising-edge detector that produces a 1-cycle pulse `ent_p`.
- States and codes: S_A = 00, S_B = 01, S_ADD = 10, S_SHOW = 11.
- Transitions:
  - S_A on `ent_p`: `op_a <= sw`, `op_b <= 0`, `ovf <= 0`, go to S_B.
  - S_B on `ent_p`: `op_b <= sw`, go to S_ADD.
  - S_ADD, unconditionally: `{cout, sum} <= op_a + op_b` as a (WIDTH+1)-bit add. If the chain is accumulating, `ovf <= ovf | carry`. Go to S_SHOW.
  - S_SHOW on `ent_p` with `mode` = 0: `op_a <= sw`, `op_b <= 0`, `ovf <= 0`, go to S_B. This starts a new pair with `sw` as A.
  - S_SHOW on `ent_p` with `mode` = 1: `op_a <= sum`, `op_b <= sw`, set the chain flag, go to S_ADD.
- The chain flag is set by an accumulate step and cleared by a mode-0 step, S_A entry, `clr`, or `reset`. `ovf` only accumulates while the flag is set.
- Without `ent_p`, every state except S_ADD holds and all outputs hold.
- `ent_p` arriving in S_ADD is ignored. It cannot occur in practice (minimum pulse spacing is 2 cycles), but it must not corrupt state.
- Synchronized `clr` takes priority over `ent_p` in the same cycle: go to S_A and zero `op_a`, `op_b`, `sum`, `cout`, `ovf`, and the chain flag.
- `mode` changes outside an S_SHOW pulse have no effect.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported through `cout`/`ovf` and is never saturated.

## Timing

- Reset values: state = S_A; `op_a`, `op_b`, `sum` = 0; `cout`, `ovf`, `valid` = 0; chain flag = 0; synchronizer and edge flops = 0.
- `ent_p` is high for exactly one cycle, SYNC_STAGES+1 cycles after the first `Clk` edge that samples `enter` high. Holding `enter` high produces exactly one pulse. A new pulse needs `enter` to be seen low for at least one synchronized cycle.
- Operand register updates are visible the cycle after `ent_p`.
- Add latency: B is latched at edge k, and `sum`/`cout` are valid with `valid` = 1 after edge k+1.
- Accumulate step: `ent_p` at edge k gives the new sum after edge k+1.
- `valid` falls in the same cycle that the state leaves S_SHOW.
- `reset` asserted mid-operation forces reset values immediately, with no dependence on `Clk`.

## Structure

- Shared package `adder_seq_pkg` holds:
  - the state codes S_A/S_B/S_ADD/S_SHOW as 2-bit localparams;
  - the default WIDTH.
- One sub-module, `sync_edge`: a `SYNC_STAGES`-flop synchronizer with an optional rising-edge pulse output.
  - Instantiated for `enter` with the edge output.
  - Instantiated for `clr` as level only.
- FSM and datapath registers sit in the top. The adder is a single expression; the hex decoding remains external.

## Test plan

- Pairwise add: reset, `sw` = 0x3C with enter, then `sw` = 0x05 with enter. Required: `op_a` = 0x3C, `op_b` = 0x05, `sum` = 0x41, `cout` = 0, `valid` = 1 two cycles after the B pulse.
- Carry: A = 0xFF, B = 0x01. Required: `sum` = 0x00, `cout` = 1, `ovf` = 0 (not chaining).
- Accumulate: A = 0x80, B = 0x80 (`sum` = 0x00, `cout` = 1), then `mode` = 1 with `sw` = 0x01. Required: `op_a` = 0x00, `sum` = 0x01, `cout` = 0, `ovf` = 1. A following mode-0 enter clears `ovf` to 0.
- Held key: `enter` high for 20 cycles in S_A. Required: exactly one pulse, state = S_B, and `op_a` does not reload.
- `clr` and `enter` asserted in the same synchronized cycle while in S_B. Required: state = S_A and all data outputs are 0.
- `reset` asserted asynchronously while in S_SHOW between clock edges. Required: outputs go to reset values before the next `Clk` edge; the next pair then adds correctly.
